dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder for the ALU pipeline's load/store path. Accepts one memory request per
//  cycle from execute 1 and returns load data on x2_mem aligned to execute 2, one cycle later.
//  Vector requests (VLEN lanes) are sequenced one lane per cycle. The pipeline is held by deasserting
//  req_ready until the vector request completes.
// PARAMETERS
//  DEPTH  256  words of storage; word index = addr[15:1] mod DEPTH
//  VLEN   4    lanes per vector request, >=2
// PORTS
//  clk         in   1         single clock, all state on posedge
//  rst_n       in   1         asynchronous active-low reset
//  req_valid   in   1         request present this cycle
//  req_ready   out  1         responder can accept; transfer = req_valid & req_ready
//  req_ins     in   16        instruction; opcode [15:12], subcode [7:4]
//  req_addr    in   16        byte address, word aligned; lane i uses req_addr + 2*i
//  req_wdata   in   16        scalar store data
//  req_vwdata  in   16*VLEN   vector store data, lane i in [16*i+15:16*i]
//  x2_mem      out  16        scalar load data / vector broadcast word
//  x2_vmem     out  16*VLEN   vector load data, lane order as req_vwdata
//  rsp_valid   out  1         one-cycle pulse: x2_mem/x2_vmem carry a fresh load result
//  stall       out  1         equals ~req_ready
// BEHAVIOUR
//  Reset: x2_mem=0, x2_vmem=0, rsp_valid=0, req_ready=1, state IDLE, lane counter 0. Memory array is not cleared.
//  Decode: 0100/sub0 LD, 0100/sub1 ST, 1100/sub0 VLD, 1100/sub1 VST, 1101/sub0 VBC (broadcast load).
//   Any other opcode or subcode is accepted in one cycle with no memory effect. rsp_valid stays 0 and outputs hold.
//  LD: accepted at edge N; the word is read combinationally and registered at N. x2_mem and rsp_valid
//   are valid in cycle N+1, so latency is 1. VBC also loads every x2_vmem lane with the word.
//  ST: mem[word] <= req_wdata at the accept edge. No response.
//  FSM states IDLE, VLD, VST. Lane counter lc ranges 0..VLEN-1. Base address and vwdata are latched at accept.
//   IDLE --VLD accept--> VLD: lane 0 is captured at the accept edge, lc=1, req_ready=0.
//   VLD: captures lane lc each cycle. When lc==VLEN-1 it captures the last lane, goes to IDLE and sets
//    rsp_valid=1 for one cycle, so x2_vmem is complete VLEN cycles after accept. x2_mem = lane 0.
//   IDLE --VST accept--> VST: lane 0 is written at the accept edge. Lanes 1..VLEN-1 are written on the
//    following edges. Return to IDLE after the last lane. req_ready=0 for VLEN-1 cycles.
//  Address arithmetic: 16-bit add wraps at 0xFFFF. Word index wraps mod DEPTH, so a vector wraps
//   from the top of memory to word 0. addr[0] is ignored.
//  req_valid while req_ready=0: ignored. The requester must hold the request.
//  Reset mid-burst: abort. Already-written VST lanes persist. No rsp_valid. Partially captured x2_vmem is reset to 0.
//  rsp_valid deasserts in the cycle after a pulse unless a new LD was accepted back-to-back.
// CONFIGURATION
//  DMEM_ADDR_CHECK_EN defined: adds output addr_err (1). A lane is in error when its word index is >= DEPTH
//   (no wrap) or addr[0]=1. An errored store lane is suppressed. An errored load lane returns 0.
//   addr_err pulses alongside rsp_valid for loads, or at cycle N+1 for a scalar store. For a VST it
//   pulses the cycle after the last lane is written. It is sticky across lanes of one vector.
//  DMEM_ADDR_CHECK_EN undefined: no addr_err port. Wrap-around as described above. Never errors.
// STRUCTURE
//  dmem_pkg: opcode/subcode localparams (OP_SMEM=4'b0100, OP_VMEM=4'b1100, OP_VBC=4'b1101,
//   SUB_LD=0, SUB_ST=1) and the state enum (S_IDLE, S_VLD, S_VST).
//  Sub-module dmem_array: DEPTH x 16 RAM with async read and sync write, one port. The FSM and latches stay in dmem_responder.
// TESTING
//  1 Reset, ST addr 0x0010 data 0xBEEF, then LD 0x0010 -> cycle after the LD accept: x2_mem=0xBEEF, rsp_valid=1 for one cycle.
//  2 VST addr 0x0020 vwdata {4,3,2,1}; req_ready=0 for 3 cycles. Then VLD 0x0020 -> x2_vmem={4,3,2,1} and
//    rsp_valid 4 cycles after accept. Scalar LD 0x0024 -> 3.
//  3 VBC of the word holding 0x1234 -> every lane of x2_vmem=0x1234 and x2_mem=0x1234 after 1 cycle.
//  4 VST at word DEPTH-2 (addr 0x01FC) -> lanes 2,3 land in words 0,1. With DMEM_ADDR_CHECK_EN: addr_err=1 and words 0,1 unchanged.
//  5 Back-to-back LD 0x0,0x2,0x4 -> rsp_valid high for 3 consecutive cycles with matching data. An ADD (0000) in
//    between gives no rsp_valid.
//  6 Assert rst_n=0 during the VLD lane 2 cycle -> req_ready=1, rsp_valid=0, x2_vmem=0. The next LD works normally.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   - opcode / subcode encodings of memory instructions
//   - responder FSM state enum
//   - request kind enum plus a decode helper
package dmem_pkg;

  localparam logic [3:0] OP_SMEM = 4'b0100;  // scalar LD / ST
  localparam logic [3:0] OP_VMEM = 4'b1100;  // vector VLD / VST
  localparam logic [3:0] OP_VBC  = 4'b1101;  // broadcast load

  localparam logic [3:0] SUB_LD = 4'd0;
  localparam logic [3:0] SUB_ST = 4'd1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_VLD  = 2'd1,
    S_VST  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    K_NONE = 3'd0,
    K_LD   = 3'd1,
    K_ST   = 3'd2,
    K_VLD  = 3'd3,
    K_VST  = 3'd4,
    K_VBC  = 3'd5
  } kind_e;

  // Opcode lives in ins[15:12], subcode in ins[7:4]. Anything not listed
  // decodes to K_NONE and is consumed without touching memory.
  function automatic kind_e decode(input logic [15:0] ins);
    kind_e k;
    k = K_NONE;
    unique case (ins[15:12])
      OP_SMEM: begin
        if (ins[7:4] == SUB_LD)      k = K_LD;
        else if (ins[7:4] == SUB_ST) k = K_ST;
      end
      OP_VMEM: begin
        if (ins[7:4] == SUB_LD)      k = K_VLD;
        else if (ins[7:4] == SUB_ST) k = K_VST;
      end
      OP_VBC: begin
        if (ins[7:4] == SUB_LD)      k = K_VBC;
      end
      default: k = K_NONE;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 16 single-port RAM, asynchronous read, synchronous write.
// Ports:
//   clk    in   clock, write on posedge
//   we     in   write enable
//   addr   in   word index (shared by read and write)
//   wdata  in   write data
//   rdata  out  combinational read of mem[addr]
// Contents are intentionally not reset.
module dmem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the load/store path.
// Accepts one request per cycle from execute 1 and returns load data aligned
// to execute 2. Vector requests walk one lane per cycle while req_ready is low.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both 1. While req_ready is 0 the requester holds its request
// and req_valid is ignored. rsp_valid is a single-cycle pulse qualifying
// x2_mem / x2_vmem; there is no backpressure on the response side.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (stall = ~req_ready)
//   req_ins               instruction, opcode [15:12], subcode [7:4]
//   req_addr              byte address, lane i at req_addr + 2*i
//   req_wdata             scalar store data
//   req_vwdata            vector store data, lane i at [16*i +: 16]
//   x2_mem, x2_vmem       load result (scalar / lane 0, all lanes)
//   rsp_valid             fresh load result pulse
//   stall                 pipeline hold
//   dbg_state             current FSM state (dmem_pkg::state_e encoding)
//   addr_err              only with DMEM_ADDR_CHECK_EN: out-of-range or odd
//                         address seen by the completing request
//
// Build option: DMEM_ADDR_CHECK_EN enables address range checking and the
// addr_err port. Without it addresses wrap modulo DEPTH and never error.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int VLEN  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [15:0]        req_ins,
  input  logic [15:0]        req_addr,
  input  logic [15:0]        req_wdata,
  input  logic [16*VLEN-1:0] req_vwdata,
  output logic [15:0]        x2_mem,
  output logic [16*VLEN-1:0] x2_vmem,
  output logic               rsp_valid,
  output logic               stall,
`ifdef DMEM_ADDR_CHECK_EN
  output logic               addr_err,
`endif
  output logic [1:0]         dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(VLEN);
  localparam logic [LW-1:0] LC_LAST = LW'(VLEN - 1);

  state_e        state, state_n;
  logic [LW-1:0] lc, lc_n;
  logic [15:0]   base_q;
  logic [16*VLEN-1:0] vwdata_q;

  kind_e       kind;
  logic        accept;
  logic        lc_last;
  logic [15:0] lane_addr;
  logic [AW-1:0] word_idx;
  logic        lane_err;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [15:0] load_word;

  // Word index = addr[15:1] mod DEPTH; the modulo gives vector wrap-around.
  function automatic logic [AW-1:0] to_word(input logic [15:0] a);
    logic [31:0] w;
    w = 32'(a[15:1]) % 32'(DEPTH);
    return w[AW-1:0];
  endfunction

  assign kind      = decode(req_ins);
  assign req_ready = (state == S_IDLE);
  assign stall     = ~req_ready;
  assign accept    = req_valid & req_ready;
  assign lc_last   = (lc == LC_LAST);
  assign dbg_state = state;

  // In IDLE the port serves the incoming request (lane 0); during a burst it
  // serves lane lc of the latched base address. The add wraps at 16 bits.
  assign lane_addr = (state == S_IDLE) ? req_addr : (base_q + {16'(lc), 1'b0} );
  assign word_idx  = to_word(lane_addr);

`ifdef DMEM_ADDR_CHECK_EN
  assign lane_err = (32'(lane_addr[15:1]) >= 32'(DEPTH)) | lane_addr[0];
`else
  assign lane_err = 1'b0;
`endif

  always_comb begin
    mem_we    = 1'b0;
    mem_wdata = req_wdata;
    if (state == S_IDLE) begin
      mem_we    = accept & ((kind == K_ST) | (kind == K_VST));
      mem_wdata = (kind == K_ST) ? req_wdata : req_vwdata[15:0];
    end else if (state == S_VST) begin
      mem_we    = 1'b1;
      mem_wdata = vwdata_q[int'(lc)*16 +: 16];
    end
    // errored lanes never reach memory
    mem_we = mem_we & ~lane_err;
  end

  assign load_word = lane_err ? 16'h0000 : mem_rdata;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (word_idx),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      lc    <= '0;
    end else begin
      state <= state_n;
      lc    <= lc_n;
    end
  end

  // FSM next state. Lane 0 is handled at the accept edge, so a burst enters
  // its state with lc=1 and leaves after serving lane VLEN-1.
  always_comb begin
    state_n = state;
    lc_n    = lc;
    unique case (state)
      S_IDLE: begin
        if (accept && (kind == K_VLD)) begin
          state_n = S_VLD;
          lc_n    = LW'(1);
        end else if (accept && (kind == K_VST)) begin
          state_n = S_VST;
          lc_n    = LW'(1);
        end
      end
      S_VLD, S_VST: begin
        if (lc_last) begin
          state_n = S_IDLE;
          lc_n    = '0;
        end else begin
          lc_n = lc + LW'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
        lc_n    = '0;
      end
    endcase
  end

  // Load result registers and burst latches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x2_mem    <= '0;
      x2_vmem   <= '0;
      rsp_valid <= 1'b0;
      base_q    <= '0;
      vwdata_q  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            unique case (kind)
              K_LD: begin
                x2_mem    <= load_word;
                rsp_valid <= 1'b1;
              end
              K_VBC: begin
                x2_mem    <= load_word;
                x2_vmem   <= {VLEN{load_word}};
                rsp_valid <= 1'b1;
              end
              K_VLD: begin
                x2_vmem[15:0] <= load_word;
                base_q        <= req_addr;
              end
              K_VST: begin
                base_q   <= req_addr;
                vwdata_q <= req_vwdata;
              end
              default: ;
            endcase
          end
        end
        S_VLD: begin
          x2_vmem[int'(lc)*16 +: 16] <= load_word;
          if (lc_last) begin
            // lane 0 was captured at accept and is stable by now
            x2_mem    <= x2_vmem[15:0];
            rsp_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DMEM_ADDR_CHECK_EN
  // err_acc collects lane errors across one vector; addr_err pulses once
  // when the request finishes (load response or last store lane).
  logic err_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_acc  <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      addr_err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            unique case (kind)
              K_LD, K_ST, K_VBC: addr_err <= lane_err;
              K_VLD, K_VST:      err_acc  <= lane_err;
              default: ;
            endcase
          end
        end
        S_VLD, S_VST: begin
          err_acc <= err_acc | lane_err;
          if (lc_last) addr_err <= err_acc | lane_err;
        end
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed bench for dmem_responder (DEPTH=256, VLEN=4).
// Loads push their expected {x2_vmem, x2_mem} into exp_q when issued; the
// monitor pops and compares on every rsp_valid pulse.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int VLEN  = 4;
  localparam int W     = 16 * (VLEN + 1);

  localparam logic [15:0] I_LD  = 16'h4000;
  localparam logic [15:0] I_ST  = 16'h4010;
  localparam logic [15:0] I_VLD = 16'hC000;
  localparam logic [15:0] I_VST = 16'hC010;
  localparam logic [15:0] I_VBC = 16'hD000;
  localparam logic [15:0] I_ADD = 16'h0000;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               req_valid;
  logic               req_ready;
  logic [15:0]        req_ins;
  logic [15:0]        req_addr;
  logic [15:0]        req_wdata;
  logic [16*VLEN-1:0] req_vwdata;
  logic [15:0]        x2_mem;
  logic [16*VLEN-1:0] x2_vmem;
  logic               rsp_valid;
  logic               stall;
  logic [1:0]         dbg_state;
`ifdef DMEM_ADDR_CHECK_EN
  logic               addr_err;
`endif

  dmem_responder #(.DEPTH(DEPTH), .VLEN(VLEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_ins    (req_ins),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_vwdata (req_vwdata),
    .x2_mem     (x2_mem),
    .x2_vmem    (x2_vmem),
    .rsp_valid  (rsp_valid),
    .stall      (stall),
`ifdef DMEM_ADDR_CHECK_EN
    .addr_err   (addr_err),
`endif
    .dbg_state  (dbg_state)
  );

  int n_vec = 0;
  int n_bad = 0;
  int rsp_seen = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      rsp_seen++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_rsp: got x2_mem %h with no expected entry", x2_mem);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("rsp_x2_mem", 64'(x2_mem), 64'(e[15:0]));
        check("rsp_x2_vmem", 64'(x2_vmem), 64'(e[W-1:16]));
      end
    end
  end

  // driver tasks
  task automatic expect_rsp(input logic [15:0] mem, input logic [16*VLEN-1:0] vmem);
    exp_q.push_back({vmem, mem});
  endtask

  task automatic send(input logic [15:0] ins, input logic [15:0] addr,
                      input logic [15:0] wdata, input logic [16*VLEN-1:0] vwdata);
    int n;
    @(negedge clk);
    req_valid  = 1'b1;
    req_ins    = ins;
    req_addr   = addr;
    req_wdata  = wdata;
    req_vwdata = vwdata;
    n = 0;
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("ready_timeout", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // counts negedges with req_ready low after an accept; returns on ready
  task automatic count_stall(output int cnt);
    cnt = 0;
    @(negedge clk);
    while (!req_ready && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int r0;
    logic [16*VLEN-1:0] v_bc;
    v_bc = {VLEN{16'h1234}};

    req_valid  = 1'b0;
    req_ins    = '0;
    req_addr   = '0;
    req_wdata  = '0;
    req_vwdata = '0;

    // reset state
    repeat (3) @(negedge clk);
    check("reset_req_ready", 64'(req_ready), 64'd1);
    check("reset_stall", 64'(stall), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_x2_mem", 64'(x2_mem), 64'd0);
    check("reset_x2_vmem", 64'(x2_vmem), 64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;

    // 1: store then load
    send(I_ST, 16'h0010, 16'hBEEF, '0);
    expect_rsp(16'hBEEF, '0);
    send(I_LD, 16'h0010, '0, '0);
    @(negedge clk);
    check("t1_rsp_pulse", 64'(rsp_valid), 64'd1);
    @(negedge clk);
    check("t1_rsp_drop", 64'(rsp_valid), 64'd0);

    // 2: vector store / vector load / scalar load of lane 2
    send(I_VST, 16'h0020, '0, {16'd4, 16'd3, 16'd2, 16'd1});
    count_stall(cnt);
    check("t2_vst_stall_cycles", 64'(cnt), 64'd3);
    expect_rsp(16'd1, {16'd4, 16'd3, 16'd2, 16'd1});
    send(I_VLD, 16'h0020, '0, '0);
    count_stall(cnt);
    check("t2_vld_stall_cycles", 64'(cnt), 64'd3);
    check("t2_vld_rsp_at_done", 64'(rsp_valid), 64'd1);
    expect_rsp(16'd3, {16'd4, 16'd3, 16'd2, 16'd1});
    send(I_LD, 16'h0024, '0, '0);

    // 3: broadcast load
    send(I_ST, 16'h0030, 16'h1234, '0);
    expect_rsp(16'h1234, v_bc);
    send(I_VBC, 16'h0030, '0, '0);
    @(negedge clk);
    check("t3_vbc_rsp", 64'(rsp_valid), 64'd1);

    // 4: vector store crossing the top of memory
    send(I_ST, 16'h0000, 16'h5550, '0);
    send(I_ST, 16'h0002, 16'h5551, '0);
    send(I_VST, 16'h01FC, '0, {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0});
    count_stall(cnt);
    check("t4_vst_stall_cycles", 64'(cnt), 64'd3);
`ifdef DMEM_ADDR_CHECK_EN
    check("t4_addr_err", 64'(addr_err), 64'd1);
    expect_rsp(16'h5550, v_bc);
    send(I_LD, 16'h0000, '0, '0);
    expect_rsp(16'h5551, v_bc);
    send(I_LD, 16'h0002, '0, '0);
`else
    expect_rsp(16'h00A2, v_bc);
    send(I_LD, 16'h0000, '0, '0);
    expect_rsp(16'h00A3, v_bc);
    send(I_LD, 16'h0002, '0, '0);
`endif
    expect_rsp(16'h00A1, v_bc);
    send(I_LD, 16'h01FE, '0, '0);

    // 5: back-to-back loads, then an ALU op in between
    send(I_ST, 16'h0004, 16'h0C04, '0);
    @(negedge clk);
    #1;
    r0 = rsp_seen;
`ifdef DMEM_ADDR_CHECK_EN
    expect_rsp(16'h5550, v_bc);
    expect_rsp(16'h5551, v_bc);
`else
    expect_rsp(16'h00A2, v_bc);
    expect_rsp(16'h00A3, v_bc);
`endif
    expect_rsp(16'h0C04, v_bc);
    send(I_LD, 16'h0000, '0, '0);
    send(I_LD, 16'h0002, '0, '0);
    send(I_LD, 16'h0004, '0, '0);
    @(negedge clk);
    #1;
    check("t5_b2b_rsp_count", 64'(rsp_seen - r0), 64'd3);
    @(negedge clk);
    check("t5_b2b_rsp_drop", 64'(rsp_valid), 64'd0);
`ifdef DMEM_ADDR_CHECK_EN
    expect_rsp(16'h5550, v_bc);
`else
    expect_rsp(16'h00A2, v_bc);
`endif
    send(I_LD, 16'h0000, '0, '0);
    send(I_ADD, 16'h0004, 16'hFFFF, '0);
    @(negedge clk);
    check("t5_add_no_rsp", 64'(rsp_valid), 64'd0);
    expect_rsp(16'h0C04, v_bc);
    send(I_LD, 16'h0004, '0, '0);

    // 6: reset during lane 2 of a vector load
    send(I_VLD, 16'h0020, '0, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_req_ready", 64'(req_ready), 64'd1);
    check("t6_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("t6_rst_x2_vmem", 64'(x2_vmem), 64'd0);
    check("t6_rst_x2_mem", 64'(x2_mem), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_rsp(16'hBEEF, '0);
    send(I_LD, 16'h0010, '0, '0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
